// File: rtl/umi_rx_queue.sv
// umi_rx_queue
//   Receive queue for UMI packets. Each beat is validated against its routing
//   word before storage; malformed beats are consumed and counted but never
//   stored. Bursts are tracked so a beat whose destination differs from the
//   burst's first beat is also dropped as malformed.
//
// Ports
//   clk, rst     sole clock; synchronous active-high reset
//   in_data      256-bit incoming packet (bits [255:240] carry the dest id)
//   in_dest      32-bit routing word sent with the packet
//   in_last      final beat of a burst
//   in_valid     upstream beat valid
//   in_ready     queue can accept a beat (not full; independent of ready)
//   packet/last  head entry of the queue
//   valid        queue head is valid (level != 0)
//   ready        downstream accepts the head entry
//   level        number of occupied entries
//   err_count    saturating count of dropped malformed beats
//   burst_open   a burst has started and its last beat is not yet accepted
module umi_rx_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [255:0]               in_data,
  input  logic [31:0]                in_dest,
  input  logic                       in_last,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [255:0]               packet,
  output logic                       last,
  output logic                       valid,
  input  logic                       ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                err_count,
  output logic                       burst_open
);

  localparam int DATA_W = 256;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;

  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_EMPTY = '0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Storage is never reset; only the control state below is.
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_last [DEPTH];

  logic [AW-1:0] wptr_p0;
  logic [AW-1:0] rptr_p0;
  logic [LW-1:0] level_p0;
  logic [15:0]   err_p0;
  logic          burst_p0;
  logic [15:0]   bdest_p0;

  logic dest_ok;
  logic burst_ok;
  logic acc;
  logic store;
  logic drop;
  logic pop;

  // Flags and head entry are functions of registered state only, so there is
  // no combinational path from the in_* ports to the output side.
  assign in_ready   = (level_p0 != LVL_FULL);
  assign valid      = (level_p0 != LVL_EMPTY);
  assign packet     = mem_data[rptr_p0];
  assign last       = mem_last[rptr_p0];
  assign level      = level_p0;
  assign err_count  = err_p0;
  assign burst_open = burst_p0;

  // A beat that is fine on its own is still rejected if it strays from the
  // destination of an open burst.
  assign dest_ok  = (in_dest[31:16] == 16'h0000) &&
                    (in_dest[15:0] == in_data[255:240]);
  assign burst_ok = !burst_p0 || (in_dest[15:0] == bdest_p0);
  assign acc      = in_valid && in_ready;
  assign store    = acc && dest_ok && burst_ok;
  assign drop     = acc && !(dest_ok && burst_ok);
  assign pop      = valid && ready;

  // ---- stage p0: queue storage ----
  always_ff @(posedge clk) begin
    if (store) begin
      mem_data[wptr_p0] <= in_data;
      mem_last[wptr_p0] <= in_last;
    end
  end

  // ---- stage p0: control state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_p0  <= '0;
      rptr_p0  <= '0;
      level_p0 <= '0;
      err_p0   <= '0;
      burst_p0 <= 1'b0;
      bdest_p0 <= '0;
    end else begin
      if (store) begin
        wptr_p0 <= wptr_p0 + AW'(1);
      end
      if (pop) begin
        rptr_p0 <= rptr_p0 + AW'(1);
      end
      case ({store, pop})
        2'b10:   level_p0 <= level_p0 + LW'(1);
        2'b01:   level_p0 <= level_p0 - LW'(1);
        default: level_p0 <= level_p0;
      endcase
      if (drop) begin
        err_p0 <= sat_inc16(err_p0);
      end
      if (store) begin
        // The first stored beat while no burst is open defines the burst's
        // destination; a single-beat transfer never opens one.
        if (!burst_p0) begin
          bdest_p0 <= in_dest[15:0];
        end
        burst_p0 <= !in_last;
      end
    end
  end

endmodule
